axis_width_upsizer: RTL and testbench
=====================================

AXIS_WIDTH_UPSIZER -- requirements
Module: axis_width_upsizer

Interface
REQ-001 Parameter S_DATA_WIDTH, default 256, SHALL be the slave tdata width in bits (multiple of 8, >= 8).
REQ-002 Parameter RATIO, default 2, SHALL be the number of slave beats packed per master beat (legal range 2..8, need not be a power of two).
REQ-003 Parameter CNT_WIDTH, default 32, SHALL be the width of the status counters.
REQ-004 Derived: M_DATA_WIDTH = S_DATA_WIDTH*RATIO, S_KEEP_WIDTH = S_DATA_WIDTH/8, M_KEEP_WIDTH = S_KEEP_WIDTH*RATIO.
REQ-005 axis_aclk  input  1  single clock; all logic is rising-edge.
REQ-006 axis_areset  input  1  synchronous, active-high reset.
REQ-007 s_axis_tvalid  input  1; s_axis_tready  output  1; s_axis_tdata  input  S_DATA_WIDTH; s_axis_tkeep  input  S_KEEP_WIDTH; s_axis_tlast  input  1.
REQ-008 m_axis_tvalid  output  1; m_axis_tready  input  1; m_axis_tdata  output  M_DATA_WIDTH; m_axis_tkeep  output  M_KEEP_WIDTH; m_axis_tlast  output  1.
REQ-009 stat_pkt_count  output  CNT_WIDTH  count of master beats sent with tlast=1.
REQ-010 stat_partial_count  output  CNT_WIDTH  count of master beats sent with fewer than RATIO filled lanes.

Function
REQ-011 Lane index idx (0..RATIO-1) SHALL select the slave-beat position; lane k occupies tdata[k*S_DATA_WIDTH +: S_DATA_WIDTH] and the matching tkeep slice; the first beat of each word goes to lane 0.
REQ-012 s_axis_tready SHALL equal (!m_axis_tvalid || m_axis_tready); it is independent of s_axis_tvalid and s_axis_tlast.
REQ-013 A slave beat is accepted when s_axis_tvalid && s_axis_tready.
REQ-014 Accepted beat with idx < RATIO-1 and tlast=0: data/keep SHALL be stored in accumulator lane idx, and idx SHALL increment.
REQ-015 Accepted beat with idx == RATIO-1 or tlast=1 ("completing beat"): the output register SHALL load the accumulator lanes 0..idx-1 plus the current beat in lane idx; lanes above idx SHALL have tdata=0 and tkeep=0; m_axis_tlast SHALL equal s_axis_tlast; idx SHALL return to 0; the accumulator SHALL clear.
REQ-016 Latency: m_axis_tvalid SHALL assert on the cycle after the completing beat is accepted.
REQ-017 m_axis_tvalid/tdata/tkeep/tlast SHALL hold stable while m_axis_tvalid && !m_axis_tready.
REQ-018 Output handshake without a completing beat in the same cycle: m_axis_tvalid SHALL deassert next cycle.
REQ-019 Output handshake and completing beat in the same cycle: the output register SHALL reload, and m_axis_tvalid SHALL remain 1 (full throughput, one master beat per RATIO slave cycles).
REQ-020 A tlast beat carrying tkeep=0 SHALL still occupy its lane and be forwarded with its zero keep.
REQ-021 stat_pkt_count SHALL increment by 1 on each master handshake with m_axis_tlast=1; stat_partial_count SHALL increment on each master handshake whose word was completed at idx < RATIO-1; both SHALL wrap modulo 2^CNT_WIDTH.
REQ-022 tkeep contents SHALL NOT be checked or repacked; gaps in slave tkeep pass through unchanged.

Reset
REQ-023 While axis_areset=1 at a rising edge: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, idx=0, accumulator=0, both counters=0.
REQ-024 s_axis_tready SHALL be 0 while axis_areset=1, and SHALL be 1 on the first cycle after release.
REQ-025 Reset asserted mid-packet SHALL discard the partial word and any pending output beat; the first beat accepted after release goes to lane 0.

Verification
REQ-026 Defaults, 4 back-to-back beats D0..D3 with keep all-ones, tlast on D3, m_axis_tready=1 -> two master beats {D1,D0} and {D3,D2}, keep all-ones, tlast 0 then 1, tready high throughout; stat_pkt_count=1, stat_partial_count=0.
REQ-027 Defaults, 3 beats D0..D2 with tlast on D2 -> second master beat = {256'b0,D2}, keep {32'h0,32'hFFFFFFFF}, tlast=1; stat_partial_count=1.
REQ-028 RATIO=4, 2-beat packet then 4-beat packet -> master beats keep 128'h0..0_FFFF..FFFF (lanes 0-1) then all-ones; lane order per REQ-011.
REQ-029 Defaults, m_axis_tready held 0 for 10 cycles while slave streams -> output word held stable; s_axis_tready drops after the first completing beat; no beat is lost or duplicated once ready returns.
REQ-030 Reset asserted after 1 of 2 beats, then a fresh 2-beat packet E0,E1 -> single master beat {E1,E0}, counters restart from 0.
REQ-031 Random valid/ready throttling, 10^4 packets of random length 1..17 -> scoreboard matches the byte stream exactly; counters equal the reference model's counts.

Source files
------------

// File: rtl/axis_width_upsizer.sv
// -----------------------------------------------------------------------------
// axis_width_upsizer
//
// Packs RATIO consecutive slave AXI-Stream beats into one master beat that is
// RATIO times wider. The first beat of each word lands in lane 0. A beat with
// tlast set closes the word early, and the lanes above it are sent as zero
// data with zero keep. Keep bits are never inspected or repacked.
//
// Ports
//   axis_aclk           : single clock, rising edge
//   axis_areset         : synchronous, active-high reset
//   s_axis_tvalid/tready/tdata/tkeep/tlast : narrow slave stream
//   m_axis_tvalid/tready/tdata/tkeep/tlast : wide master stream (registered)
//   stat_pkt_count      : master beats sent with tlast=1 (wraps)
//   stat_partial_count  : master beats sent with fewer than RATIO lanes filled
// -----------------------------------------------------------------------------
module axis_width_upsizer #(
    parameter int S_DATA_WIDTH = 256,
    parameter int RATIO        = 2,
    parameter int CNT_WIDTH    = 32,
    localparam int M_DATA_WIDTH = S_DATA_WIDTH * RATIO,
    localparam int S_KEEP_WIDTH = S_DATA_WIDTH / 8,
    localparam int M_KEEP_WIDTH = S_KEEP_WIDTH * RATIO
) (
    input  logic                    axis_aclk,
    input  logic                    axis_areset,

    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,

    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,

    output logic [CNT_WIDTH-1:0]    stat_pkt_count,
    output logic [CNT_WIDTH-1:0]    stat_partial_count
);

    localparam int                IDX_W    = $clog2(RATIO);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(RATIO - 1);

    logic [IDX_W-1:0]        idx;
    logic [M_DATA_WIDTH-1:0] acc_data;
    logic [M_KEEP_WIDTH-1:0] acc_keep;
    logic [M_DATA_WIDTH-1:0] nxt_data;
    logic [M_KEEP_WIDTH-1:0] nxt_keep;
    logic                    out_partial;
    logic                    s_beat;
    logic                    m_beat;
    logic                    completing;

    // The slave may only push when the output register is free or is being
    // drained this cycle. Held low during reset so nothing is accepted then.
    assign s_axis_tready = !axis_areset && (!m_axis_tvalid || m_axis_tready);
    assign s_beat        = s_axis_tvalid && s_axis_tready;
    assign m_beat        = m_axis_tvalid && m_axis_tready;
    assign completing    = (idx == LAST_IDX) || s_axis_tlast;

    // Merge the incoming beat into lane idx of the accumulator. Lanes at and
    // above idx are always zero in the accumulator (it is cleared after every
    // word), so the merged value already has zero data/keep above idx and can
    // be loaded straight into the output register on a completing beat.
    always_comb begin
        nxt_data = acc_data;
        nxt_keep = acc_keep;
        for (int k = 0; k < RATIO; k++) begin
            if (idx == IDX_W'(k)) begin
                nxt_data[k*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
                nxt_keep[k*S_KEEP_WIDTH +: S_KEEP_WIDTH] = s_axis_tkeep;
            end
        end
    end

    // Lane accumulator and output register. A drain and a reload may happen
    // in the same cycle; the reload is written last so it wins and tvalid
    // stays high, giving one master beat every RATIO slave cycles.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            idx           <= '0;
            acc_data      <= '0;
            acc_keep      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            out_partial   <= 1'b0;
        end else begin
            if (m_beat) begin
                m_axis_tvalid <= 1'b0;
            end
            if (s_beat) begin
                if (completing) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= nxt_data;
                    m_axis_tkeep  <= nxt_keep;
                    m_axis_tlast  <= s_axis_tlast;
                    out_partial   <= (idx != LAST_IDX);
                    idx           <= '0;
                    acc_data      <= '0;
                    acc_keep      <= '0;
                end else begin
                    idx      <= idx + IDX_W'(1);
                    acc_data <= nxt_data;
                    acc_keep <= nxt_keep;
                end
            end
        end
    end

    // Status counters advance on the master handshake, so a word that is
    // discarded by reset before it leaves is never counted.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            stat_pkt_count     <= '0;
            stat_partial_count <= '0;
        end else if (m_beat) begin
            if (m_axis_tlast) begin
                stat_pkt_count <= stat_pkt_count + CNT_WIDTH'(1);
            end
            if (out_partial) begin
                stat_partial_count <= stat_partial_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_width_upsizer.sv
// -----------------------------------------------------------------------------
// tb_axis_width_upsizer
//
// dut0 : default parameters (256-bit slave, RATIO 2), driven from a table of
//        per-cycle vectors with hand-computed expectations, then a mid-packet
//        reset sequence.
// dut1 : 8-bit slave, RATIO 4, for lane ordering on a wide ratio and a
//        throttled random stream checked against a queue of expected words.
// -----------------------------------------------------------------------------
module tb_axis_width_upsizer;

    logic clk;
    logic rst;

    // dut0 signals
    logic         s0_valid, s0_ready, s0_last;
    logic [255:0] s0_data;
    logic [31:0]  s0_keep;
    logic         m0_valid, m0_ready, m0_last;
    logic [511:0] m0_data;
    logic [63:0]  m0_keep;
    logic [31:0]  pkt0, part0;

    // dut1 signals
    logic         s1_valid, s1_ready, s1_last;
    logic [7:0]   s1_data;
    logic [0:0]   s1_keep;
    logic         m1_valid, m1_ready, m1_last;
    logic [31:0]  m1_data;
    logic [3:0]   m1_keep;
    logic [15:0]  pkt1, part1;

    int checks = 0;
    int errors = 0;

    axis_width_upsizer dut0 (
        .axis_aclk          (clk),
        .axis_areset        (rst),
        .s_axis_tvalid      (s0_valid),
        .s_axis_tready      (s0_ready),
        .s_axis_tdata       (s0_data),
        .s_axis_tkeep       (s0_keep),
        .s_axis_tlast       (s0_last),
        .m_axis_tvalid      (m0_valid),
        .m_axis_tready      (m0_ready),
        .m_axis_tdata       (m0_data),
        .m_axis_tkeep       (m0_keep),
        .m_axis_tlast       (m0_last),
        .stat_pkt_count     (pkt0),
        .stat_partial_count (part0)
    );

    axis_width_upsizer #(.S_DATA_WIDTH(8), .RATIO(4), .CNT_WIDTH(16)) dut1 (
        .axis_aclk          (clk),
        .axis_areset        (rst),
        .s_axis_tvalid      (s1_valid),
        .s_axis_tready      (s1_ready),
        .s_axis_tdata       (s1_data),
        .s_axis_tkeep       (s1_keep),
        .s_axis_tlast       (s1_last),
        .m_axis_tvalid      (m1_valid),
        .m_axis_tready      (m1_ready),
        .m_axis_tdata       (m1_data),
        .m_axis_tkeep       (m1_keep),
        .m_axis_tlast       (m1_last),
        .stat_pkt_count     (pkt1),
        .stat_partial_count (part1)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One table row: inputs held for one cycle, tready expected before the
    // edge, master outputs and counters expected just after it.
    typedef struct {
        logic         sv;
        logic [255:0] sd;
        logic [31:0]  sk;
        logic         sl;
        logic         mr;
        logic         exp_sr;
        logic         exp_mv;
        logic         chk;
        logic [511:0] exp_md;
        logic [63:0]  exp_mk;
        logic         exp_ml;
        int           exp_pkt;
        int           exp_part;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    localparam logic [31:0] K1 = 32'hFFFF_FFFF;
    localparam logic [31:0] K0 = 32'h0;

    // Distinct recognisable 256-bit beat patterns
    function automatic logic [255:0] pat(input int n);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(n);
        return {8{w}};
    endfunction

    function automatic vec_t mk(input logic sv, input logic [255:0] sd, input logic [31:0] sk,
                                input logic sl, input logic mr, input logic exp_sr,
                                input logic exp_mv, input logic chk, input logic [511:0] exp_md,
                                input logic [63:0] exp_mk, input logic exp_ml,
                                input int exp_pkt, input int exp_part);
        vec_t v;
        v.sv = sv; v.sd = sd; v.sk = sk; v.sl = sl; v.mr = mr;
        v.exp_sr = exp_sr; v.exp_mv = exp_mv; v.chk = chk;
        v.exp_md = exp_md; v.exp_mk = exp_mk; v.exp_ml = exp_ml;
        v.exp_pkt = exp_pkt; v.exp_part = exp_part;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one table row, check tready before the edge and the rest after
    task automatic applyStimulus(input int i);
        @(negedge clk);
        s0_valid = vecs[i].sv;
        s0_data  = vecs[i].sd;
        s0_keep  = vecs[i].sk;
        s0_last  = vecs[i].sl;
        m0_ready = vecs[i].mr;
        #1;
        checkOutput($sformatf("v%0d_sready", i), 512'(s0_ready), 512'(vecs[i].exp_sr));
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d_mvalid", i), 512'(m0_valid), 512'(vecs[i].exp_mv));
        if (vecs[i].chk) begin
            checkOutput($sformatf("v%0d_mdata", i), m0_data, vecs[i].exp_md);
            checkOutput($sformatf("v%0d_mkeep", i), 512'(m0_keep), 512'(vecs[i].exp_mk));
            checkOutput($sformatf("v%0d_mlast", i), 512'(m0_last), 512'(vecs[i].exp_ml));
        end
        checkOutput($sformatf("v%0d_pkt", i), 512'(pkt0), 512'(vecs[i].exp_pkt));
        checkOutput($sformatf("v%0d_part", i), 512'(part0), 512'(vecs[i].exp_part));
    endtask

    // dut1 single-beat driver with an after-edge check of the master side
    task automatic drive1(input logic v, input logic [7:0] d, input logic l, input logic mr);
        @(negedge clk);
        s1_valid = v;
        s1_data  = d;
        s1_keep  = 1'b1;
        s1_last  = l;
        m1_ready = mr;
        @(posedge clk);
        #1;
    endtask

    // Random-stream model state
    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        p;
    } word_t;
    word_t       expq[$];
    word_t       w;
    logic [31:0] mdata;
    logic [3:0]  mkeep;
    int          lane;
    int          rem;
    int          pkts_sent;
    int          mpkt;
    int          mpart;
    int          cyc;
    logic        have;
    logic [7:0]  cur_d;
    logic        cur_k;
    logic        cur_l;
    logic        acc;
    logic        mh;

    localparam int NPKT = 300;

    initial begin
        rst = 1'b1;
        s0_valid = 0; s0_data = '0; s0_keep = '0; s0_last = 0; m0_ready = 0;
        s1_valid = 0; s1_data = '0; s1_keep = '0; s1_last = 0; m1_ready = 0;

        // Full 4-beat packet, 3-beat packet with a half word, backpressure,
        // and a zero-keep tlast beat reloaded in the same cycle as a drain.
        vecs[0]  = mk(1, pat(0), K1, 0, 1, 1, 0, 0, '0, '0, 0, 0, 0);
        vecs[1]  = mk(1, pat(1), K1, 0, 1, 1, 1, 1, {pat(1), pat(0)}, {K1, K1}, 0, 0, 0);
        vecs[2]  = mk(1, pat(2), K1, 0, 1, 1, 0, 0, '0, '0, 0, 0, 0);
        vecs[3]  = mk(1, pat(3), K1, 1, 1, 1, 1, 1, {pat(3), pat(2)}, {K1, K1}, 1, 0, 0);
        vecs[4]  = mk(0, '0,     K0, 0, 1, 1, 0, 0, '0, '0, 0, 1, 0);
        vecs[5]  = mk(1, pat(10), K1, 0, 1, 1, 0, 0, '0, '0, 0, 1, 0);
        vecs[6]  = mk(1, pat(11), K1, 0, 1, 1, 1, 1, {pat(11), pat(10)}, {K1, K1}, 0, 1, 0);
        vecs[7]  = mk(1, pat(12), K1, 1, 1, 1, 1, 1, {256'b0, pat(12)}, {K0, K1}, 1, 1, 0);
        vecs[8]  = mk(0, '0,     K0, 0, 1, 1, 0, 0, '0, '0, 0, 2, 1);
        vecs[9]  = mk(1, pat(20), K1, 0, 0, 1, 0, 0, '0, '0, 0, 2, 1);
        vecs[10] = mk(1, pat(21), K1, 0, 0, 1, 1, 1, {pat(21), pat(20)}, {K1, K1}, 0, 2, 1);
        vecs[11] = mk(1, pat(22), K1, 0, 0, 0, 1, 1, {pat(21), pat(20)}, {K1, K1}, 0, 2, 1);
        vecs[12] = mk(1, pat(22), K1, 0, 0, 0, 1, 1, {pat(21), pat(20)}, {K1, K1}, 0, 2, 1);
        vecs[13] = mk(1, pat(22), K1, 0, 1, 1, 0, 0, '0, '0, 0, 2, 1);
        vecs[14] = mk(1, pat(23), K1, 1, 1, 1, 1, 1, {pat(23), pat(22)}, {K1, K1}, 1, 2, 1);
        vecs[15] = mk(0, '0,     K0, 0, 1, 1, 0, 0, '0, '0, 0, 3, 1);
        vecs[16] = mk(1, pat(30), K1, 1, 1, 1, 1, 1, {256'b0, pat(30)}, {K0, K1}, 1, 3, 1);
        vecs[17] = mk(1, pat(31), K0, 1, 1, 1, 1, 1, {256'b0, pat(31)}, {K0, K0}, 1, 4, 2);
        vecs[18] = mk(0, '0,     K0, 0, 1, 1, 0, 0, '0, '0, 0, 5, 3);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_sready", 512'(s0_ready), 512'(0));
        checkOutput("rst_mvalid", 512'(m0_valid), 512'(0));
        checkOutput("rst_mdata", m0_data, 512'(0));
        checkOutput("rst_mkeep", 512'(m0_keep), 512'(0));
        checkOutput("rst_mlast", 512'(m0_last), 512'(0));
        checkOutput("rst_pkt", 512'(pkt0), 512'(0));
        checkOutput("rst_part", 512'(part0), 512'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(i);
        end

        // Reset mid-packet with a pending output word, then a fresh packet
        @(negedge clk);
        s0_valid = 1; s0_data = pat(40); s0_keep = K1; s0_last = 0; m0_ready = 0;
        @(negedge clk);
        s0_data = pat(41);
        @(negedge clk);
        s0_data = pat(42);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_sready", 512'(s0_ready), 512'(0));
        @(posedge clk);
        #1;
        checkOutput("mid_rst_mvalid", 512'(m0_valid), 512'(0));
        checkOutput("mid_rst_pkt", 512'(pkt0), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        s0_data = pat(50); s0_last = 0; m0_ready = 1;
        #1;
        checkOutput("post_rst_sready", 512'(s0_ready), 512'(1));
        @(posedge clk);
        #1;
        checkOutput("post_rst_e0_mvalid", 512'(m0_valid), 512'(0));
        @(negedge clk);
        s0_data = pat(51); s0_last = 1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_mvalid", 512'(m0_valid), 512'(1));
        checkOutput("post_rst_mdata", m0_data, {pat(51), pat(50)});
        checkOutput("post_rst_mlast", 512'(m0_last), 512'(1));
        @(negedge clk);
        s0_valid = 0; s0_last = 0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_pkt", 512'(pkt0), 512'(1));
        checkOutput("post_rst_part", 512'(part0), 512'(0));

        // RATIO 4: 2-beat packet then 4-beat packet
        drive1(1, 8'h11, 0, 1);
        drive1(1, 8'h22, 1, 1);
        checkOutput("r4_a_data", 512'(m1_data), 512'(32'h0000_2211));
        checkOutput("r4_a_keep", 512'(m1_keep), 512'(4'b0011));
        checkOutput("r4_a_last", 512'(m1_last), 512'(1));
        drive1(1, 8'h33, 0, 1);
        drive1(1, 8'h44, 0, 1);
        drive1(1, 8'h55, 0, 1);
        drive1(1, 8'h66, 1, 1);
        checkOutput("r4_b_valid", 512'(m1_valid), 512'(1));
        checkOutput("r4_b_data", 512'(m1_data), 512'(32'h6655_4433));
        checkOutput("r4_b_keep", 512'(m1_keep), 512'(4'b1111));
        drive1(0, 8'h00, 0, 1);
        checkOutput("r4_pkt", 512'(pkt1), 512'(2));
        checkOutput("r4_part", 512'(part1), 512'(1));

        // Throttled random stream on dut1
        @(negedge clk);
        rst = 1'b1;
        s1_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        mdata = '0; mkeep = '0; lane = 0; mpkt = 0; mpart = 0;
        pkts_sent = 0; have = 0; rem = $urandom_range(1, 17);
        cyc = 0;
        while (!(pkts_sent == NPKT && expq.size() == 0 && !m1_valid) && cyc < 40000) begin
            if (!have && pkts_sent < NPKT) begin
                cur_d = 8'($urandom);
                cur_k = 1'($urandom);
                cur_l = (rem == 1);
                have  = 1;
            end
            s1_valid = have && ($urandom_range(0, 3) != 0);
            s1_data  = cur_d;
            s1_keep  = cur_k;
            s1_last  = cur_l;
            m1_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = s1_valid && s1_ready;
            mh  = m1_valid && m1_ready;
            if (mh) begin
                if (expq.size() == 0) begin
                    checkOutput("rnd_unexpected_word", 512'(1), 512'(0));
                end else begin
                    w = expq.pop_front();
                    checkOutput("rnd_data", 512'(m1_data), 512'(w.d));
                    checkOutput("rnd_keep", 512'(m1_keep), 512'(w.k));
                    checkOutput("rnd_last", 512'(m1_last), 512'(w.l));
                    if (w.l) mpkt++;
                    if (w.p) mpart++;
                end
            end
            if (acc) begin
                mdata[lane*8 +: 8] = cur_d;
                mkeep[lane]        = cur_k;
                if (lane == 3 || cur_l) begin
                    w.d = mdata; w.k = mkeep; w.l = cur_l; w.p = (lane != 3);
                    expq.push_back(w);
                    mdata = '0; mkeep = '0; lane = 0;
                end else begin
                    lane++;
                end
                have = 0;
                if (cur_l) begin
                    pkts_sent++;
                    rem = $urandom_range(1, 17);
                end else begin
                    rem--;
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        s1_valid = 0;
        if (cyc >= 40000) begin
            checkOutput("rnd_timeout", 512'(cyc), 512'(0));
        end
        #1;
        checkOutput("rnd_pkt_count", 512'(pkt1), 512'(16'(mpkt)));
        checkOutput("rnd_part_count", 512'(part1), 512'(16'(mpart)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
